// File: rtl/spi_pkg.sv
// Shared definitions for the SPI packet master: FSM states and byte width.
package spi_pkg;

  localparam int BYTE_SIZE = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HIGH,
    SCK_LOW,
    GAP
  } spiState_e;

endpackage

// File: rtl/spi_packet_master_if.sv
// Host handshake and SPI pin bundle for spi_packet_master.
interface spi_packet_master_if #(
  parameter int PACKET_SIZE = 32
);
  import spi_pkg::*;

  localparam int DATA_W = BYTE_SIZE * PACKET_SIZE;

  logic              startIn;
  logic              abortIn;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;
  logic              doneOut;
  logic              busyOut;
  logic              ssOut;
  logic              sckOut;
  logic              mosiOut;
  logic              misoIn;

  modport master (
    input  startIn, abortIn, dataIn, misoIn,
    output dataOut, doneOut, busyOut, ssOut, sckOut, mosiOut
  );

  modport slave (
    output startIn, abortIn, dataIn, misoIn,
    input  dataOut, doneOut, busyOut, ssOut, sckOut, mosiOut
  );

endinterface

// File: rtl/spi_half_period_timer.sv
// Down-counter that times SCK half-periods and the inter-packet gap.
// tick is high during the last cycle of a loaded interval.
module spi_half_period_timer #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic clk,
  input  logic nResetIn,
  input  logic load,
  input  logic loadGap,
  output logic tick
);

  localparam int MAX_LOAD = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W    = $clog2(MAX_LOAD + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge nResetIn) begin
    if (!nResetIn) begin
      count <= '0;
    end else if (load) begin
      count <= loadGap ? GAP_LOAD : DIV_LOAD;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tick = (count == CNT_W'(1));

endmodule

// File: rtl/spi_packet_master.sv
// SPI mode-0 master that shifts one PACKET_SIZE-byte packet per start request.
//
// state    | meaning
// IDLE     | ssOut high, waiting for startIn
// SETUP    | ssOut low, first MOSI bit presented before the first SCK rise
// SCK_HIGH | sckOut high; MISO sampled and MOSI advanced on the closing edge
// SCK_LOW  | sckOut low; the last one doubles as ssOut hold time
// GAP      | ssOut high, busy, minimum deselect time between packets
module spi_packet_master
  import spi_pkg::*;
#(
  parameter int PACKET_SIZE = 32,
  parameter int CLK_DIV     = 4,
  parameter int GAP_CYCLES  = 4
) (
  input logic                 clk,
  input logic                 nResetIn,
  spi_packet_master_if.master bus
);

  localparam int DATA_W = BYTE_SIZE * PACKET_SIZE;
  localparam int BIT_W  = $clog2(DATA_W + 1);

  spiState_e         state;
  spiState_e         nextState;
  logic [DATA_W-1:0] txShift;
  logic [DATA_W-1:0] rxShift;
  logic [DATA_W-1:0] dataReg;
  logic [BIT_W-1:0]  bitCnt;
  logic              doneReg;
  logic              tick;
  logic              timerLoad;
  logic              timerLoadGap;
  logic              accept;
  logic              sampleBit;
  logic              finish;
  logic              ssInt;

  spi_half_period_timer #(
    .CLK_DIV   (CLK_DIV),
    .GAP_CYCLES(GAP_CYCLES)
  ) u_timer (
    .clk     (clk),
    .nResetIn(nResetIn),
    .load    (timerLoad),
    .loadGap (timerLoadGap),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge nResetIn) begin
    if (!nResetIn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState    = state;
    timerLoad    = 1'b0;
    timerLoadGap = 1'b0;
    accept       = 1'b0;
    sampleBit    = 1'b0;
    finish       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.startIn) begin
          nextState = SETUP;
          timerLoad = 1'b1;
          accept    = 1'b1;
        end
      end
      SETUP: begin
        if (tick) begin
          nextState = SCK_HIGH;
          timerLoad = 1'b1;
        end
      end
      SCK_HIGH: begin
        if (tick) begin
          nextState = SCK_LOW;
          timerLoad = 1'b1;
          sampleBit = 1'b1;
        end
      end
      SCK_LOW: begin
        if (tick) begin
          timerLoad = 1'b1;
          if (bitCnt == '0) begin
            nextState    = GAP;
            timerLoadGap = 1'b1;
            finish       = 1'b1;
          end else begin
            nextState = SCK_HIGH;
          end
        end
      end
      GAP: begin
        if (tick) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    // Abort overrides any same-edge completion or bit sample.
    if (bus.abortIn && (state inside {SETUP, SCK_HIGH, SCK_LOW})) begin
      nextState    = GAP;
      timerLoad    = 1'b1;
      timerLoadGap = 1'b1;
      sampleBit    = 1'b0;
      finish       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nResetIn) begin
    if (!nResetIn) begin
      txShift <= '0;
      rxShift <= '0;
      dataReg <= '0;
      bitCnt  <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= finish;
      if (accept) begin
        txShift <= bus.dataIn;
        bitCnt  <= BIT_W'(DATA_W);
      end else if (sampleBit) begin
        txShift <= {txShift[DATA_W-2:0], 1'b0};
        rxShift <= {rxShift[DATA_W-2:0], bus.misoIn};
        bitCnt  <= bitCnt - BIT_W'(1);
      end
      if (finish) begin
        dataReg <= rxShift;
      end
    end
  end

  assign ssInt       = (state == IDLE) || (state == GAP);
  assign bus.ssOut   = ssInt;
  assign bus.sckOut  = (state == SCK_HIGH);
  assign bus.mosiOut = !ssInt && txShift[DATA_W-1];
  assign bus.busyOut = (state != IDLE);
  assign bus.doneOut = doneReg;
  assign bus.dataOut = dataReg;

endmodule

// File: tb/tb_spi_packet_master.sv
// Directed bench for spi_packet_master: 2-byte packets, CLK_DIV=2, GAP_CYCLES=3.
module tb_spi_packet_master;

  localparam int PS  = 2;
  localparam int DIV = 2;
  localparam int GAP = 3;
  localparam int DONE_CYC = 1 + DIV * (16 * PS + 1);

  logic clk = 1'b0;
  logic nResetIn;
  logic misoTie;

  int checks = 0;
  int errors = 0;

  int cyc, doneCnt, doneCyc, done2Cyc, rises, mosiOnes, unstable, mosiSsHigh;
  logic prevSck, prevMosi;

  spi_packet_master_if #(.PACKET_SIZE(PS)) bus ();

  spi_packet_master #(
    .PACKET_SIZE(PS),
    .CLK_DIV    (DIV),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk     (clk),
    .nResetIn(nResetIn),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.misoIn = misoTie ? 1'b1 : bus.mosiOut;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clearMon();
    cyc = 0; doneCnt = 0; doneCyc = 0; done2Cyc = 0; rises = 0;
    mosiOnes = 0; unstable = 0; mosiSsHigh = 0;
    prevSck = bus.sckOut; prevMosi = bus.mosiOut;
  endtask

  // One clock; samples 1 time unit after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.doneOut) begin
      doneCnt++;
      if (doneCnt == 1) doneCyc = cyc;
      if (doneCnt == 2) done2Cyc = cyc;
    end
    if (bus.sckOut && !prevSck) rises++;
    if (bus.sckOut && prevSck && bus.mosiOut !== prevMosi) unstable++;
    if (!bus.ssOut && bus.mosiOut) mosiOnes++;
    if (bus.ssOut && bus.mosiOut) mosiSsHigh++;
    prevSck = bus.sckOut;
    prevMosi = bus.mosiOut;
  endtask

  task automatic runPacket(input logic [15:0] data, input logic [15:0] expRx,
                           input logic mosiLowOnly, input string tag);
    bus.dataIn = data;
    bus.startIn = 1'b1;
    clearMon();
    stepCycle();
    bus.startIn = 1'b0;
    checkVal({tag, "_busy1"}, 32'(bus.busyOut), 32'd1);
    checkVal({tag, "_ss1"}, 32'(bus.ssOut), 32'd0);
    checkVal({tag, "_mosi1"}, 32'(bus.mosiOut), 32'(data[15]));
    for (int i = 0; i < 300 && bus.busyOut; i++) stepCycle();
    checkVal({tag, "_busyEnd"}, 32'(bus.busyOut), 32'd0);
    checkVal({tag, "_doneCyc"}, doneCyc, DONE_CYC);
    checkVal({tag, "_doneCnt"}, doneCnt, 32'd1);
    checkVal({tag, "_rises"}, rises, 32'd16);
    checkVal({tag, "_mosiStable"}, unstable, 32'd0);
    checkVal({tag, "_mosiSsHigh"}, mosiSsHigh, 32'd0);
    checkVal({tag, "_dataOut"}, 32'(bus.dataOut), 32'(expRx));
    if (mosiLowOnly) checkVal({tag, "_mosiOnes"}, mosiOnes, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    nResetIn = 1'b1;
    misoTie = 1'b0;
    bus.startIn = 1'b0;
    bus.abortIn = 1'b0;
    bus.dataIn = '0;
    #1 nResetIn = 1'b0;
    #10;
    checkVal("rst_ss", 32'(bus.ssOut), 32'd1);
    checkVal("rst_sck", 32'(bus.sckOut), 32'd0);
    checkVal("rst_mosi", 32'(bus.mosiOut), 32'd0);
    checkVal("rst_done", 32'(bus.doneOut), 32'd0);
    checkVal("rst_busy", 32'(bus.busyOut), 32'd0);
    checkVal("rst_data", 32'(bus.dataOut), 32'd0);

    // Release reset and start together: the first edge after release accepts.
    nResetIn = 1'b1;
    runPacket(16'hA55A, 16'hA55A, 1'b0, "loop");

    misoTie = 1'b1;
    runPacket(16'h0000, 16'hFFFF, 1'b1, "miso1");
    misoTie = 1'b0;

    // startIn held high: back-to-back packets.
    bus.dataIn = 16'h1234;
    bus.startIn = 1'b1;
    clearMon();
    begin
      int ssFall;
      logic prevSs;
      ssFall = 0;
      prevSs = 1'b1;
      for (int i = 0; i < 400 && !(doneCnt == 2 && !bus.busyOut); i++) begin
        stepCycle();
        if (prevSs && !bus.ssOut && doneCnt == 1 && ssFall == 0) ssFall = cyc;
        prevSs = bus.ssOut;
        if (doneCnt == 2) bus.startIn = 1'b0;
      end
      bus.startIn = 1'b0;
      checkVal("held_done1", doneCyc, DONE_CYC);
      checkVal("held_ssGap", ssFall - doneCyc, GAP + 1);
      checkVal("held_done2", done2Cyc, ssFall + DONE_CYC - 1);
      checkVal("held_doneCnt", doneCnt, 32'd2);
      checkVal("held_data", 32'(bus.dataOut), 32'h1234);
    end

    // Abort after the 5th SCK rise.
    bus.dataIn = 16'hFFFF;
    bus.startIn = 1'b1;
    clearMon();
    stepCycle();
    bus.startIn = 1'b0;
    for (int i = 0; i < 100 && rises < 5; i++) stepCycle();
    checkVal("abort_rises", rises, 32'd5);
    bus.abortIn = 1'b1;
    stepCycle();
    bus.abortIn = 1'b0;
    checkVal("abort_ss", 32'(bus.ssOut), 32'd1);
    checkVal("abort_sck", 32'(bus.sckOut), 32'd0);
    checkVal("abort_mosi", 32'(bus.mosiOut), 32'd0);
    checkVal("abort_busy", 32'(bus.busyOut), 32'd1);
    for (int i = 0; i < 100 && bus.busyOut; i++) stepCycle();
    checkVal("abort_busyEnd", 32'(bus.busyOut), 32'd0);
    checkVal("abort_noDone", doneCnt, 32'd0);
    checkVal("abort_data", 32'(bus.dataOut), 32'h1234);

    // abortIn while idle must not disturb the next packet.
    bus.abortIn = 1'b1;
    stepCycle();
    bus.abortIn = 1'b0;
    checkVal("idleAbort_busy", 32'(bus.busyOut), 32'd0);

    // startIn pulsed mid-transfer is ignored.
    bus.dataIn = 16'h0F0F;
    bus.startIn = 1'b1;
    clearMon();
    stepCycle();
    bus.startIn = 1'b0;
    repeat (20) stepCycle();
    bus.startIn = 1'b1;
    bus.dataIn = 16'hBEEF;
    stepCycle();
    bus.startIn = 1'b0;
    for (int i = 0; i < 200 && bus.busyOut; i++) stepCycle();
    repeat (5) stepCycle();
    checkVal("midStart_doneCnt", doneCnt, 32'd1);
    checkVal("midStart_data", 32'(bus.dataOut), 32'h0F0F);
    checkVal("midStart_idle", 32'(bus.busyOut), 32'd0);

    // Reset mid-transfer: asynchronous, partial packet discarded.
    bus.dataIn = 16'hC3C3;
    bus.startIn = 1'b1;
    clearMon();
    stepCycle();
    bus.startIn = 1'b0;
    repeat (30) stepCycle();
    checkVal("rstMid_ssBefore", 32'(bus.ssOut), 32'd0);
    #3 nResetIn = 1'b0;
    #1;
    checkVal("rstMid_ss", 32'(bus.ssOut), 32'd1);
    checkVal("rstMid_sck", 32'(bus.sckOut), 32'd0);
    checkVal("rstMid_mosi", 32'(bus.mosiOut), 32'd0);
    checkVal("rstMid_busy", 32'(bus.busyOut), 32'd0);
    checkVal("rstMid_done", 32'(bus.doneOut), 32'd0);
    checkVal("rstMid_data", 32'(bus.dataOut), 32'd0);
    repeat (2) stepCycle();
    nResetIn = 1'b1;
    clearMon();
    repeat (100) stepCycle();
    checkVal("rstMid_noDone", doneCnt, 32'd0);
    checkVal("rstMid_idle", 32'(bus.busyOut), 32'd0);
    checkVal("rstMid_dataKept", 32'(bus.dataOut), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
